// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register bank, one write port, two read ports, hardware clear sweep.
// Latency: reads are combinational (0 cycles); writes are visible after the edge; a clear takes 2**ADDR_W cycles.
// Backpressure: none; writes and clr_req arriving while busy are silently dropped.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined     -> an idle-state write whose wAddr matches rAddrX forwards wDin onto rDoutX in the same cycle
//   not defined -> read ports return stored contents only
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   rAddrA, rDoutA  read port A: address in, data out (combinational)
//   rAddrB, rDoutB  read port B: address in, data out (combinational)
//   wAddr, wDin,
//   wEna            write port, taken only while the clear sweep is idle
//   clr_req         one-cycle pulse that starts a sweep restoring every entry to its reset value
//   busy            high for exactly 2**ADDR_W cycles while the sweep runs
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int INIT0  = 2,
  parameter int INIT1  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rAddrA,
  output logic [DATA_W-1:0] rDoutA,
  input  logic [ADDR_W-1:0] rAddrB,
  output logic [DATA_W-1:0] rDoutB,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wDin,
  input  logic              wEna,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  // Reset values truncated (or extended) to the entry width.
  localparam logic [DATA_W-1:0] INIT0_V = DATA_W'(INIT0);
  localparam logic [DATA_W-1:0] INIT1_V = DATA_W'(INIT1);

  // The sweep counter carries one extra bit so the terminal compare is on the
  // full value; the last entry is written on the same edge the sweep ends.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   clrCnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Value an entry holds after reset or after being swept.
  function automatic logic [DATA_W-1:0] resetVal(input logic [ADDR_W-1:0] idx);
    if (idx == '0) begin
      return INIT0_V;
    end else if (idx == ADDR_W'(1)) begin
      return INIT1_V;
    end else begin
      return '0;
    end
  endfunction

  // Storage, sweep counter and state share one process: in CLEAR the sweep
  // owns the write port, so external writes simply have no path into mem.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= resetVal(ADDR_W'(i));
      end
      state  <= IDLE;
      clrCnt <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A write coinciding with clr_req still lands; the sweep erases it later.
          if (wEna) begin
            mem[wAddr] <= wDin;
          end
          if (clr_req) begin
            state  <= CLEAR;
            clrCnt <= '0;
            busy   <= 1'b1;
          end
        end
        CLEAR: begin
          mem[clrCnt[ADDR_W-1:0]] <= resetVal(clrCnt[ADDR_W-1:0]);
          if (clrCnt == LAST_CNT) begin
            state  <= IDLE;
            clrCnt <= '0;
            busy   <= 1'b0;
          end else begin
            clrCnt <= clrCnt + (ADDR_W + 1)'(1);
          end
        end
        default: begin
          state  <= IDLE;
          clrCnt <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward only writes that will actually commit; writes during a sweep are dropped.
  logic idleWr;
  assign idleWr = wEna && (state == IDLE);

  always_comb begin
    rDoutA = mem[rAddrA];
    if (idleWr && (wAddr == rAddrA)) begin
      rDoutA = wDin;
    end
  end

  always_comb begin
    rDoutB = mem[rAddrB];
    if (idleWr && (wAddr == rAddrB)) begin
      rDoutB = wDin;
    end
  end
`else
  assign rDoutA = mem[rAddrA];
  assign rDoutB = mem[rAddrB];
`endif

endmodule
